// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared constants and types for the pipeline hazard/stall controller.
package pipe_hazard_pkg;

   // Extra cycles for a result to reach the register file when there is no bypass.
   localparam int WB_EXTRA = 2;

   // Scoreboard counter width; covers LOAD_LAT + WB_EXTRA.
   localparam int SB_CNT_W = 3;

   typedef logic [SB_CNT_W-1:0] sb_cnt_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      DATA  = 2'd1,
      MEM   = 2'd2,
      FLUSH = 2'd3
   } stall_cause_t;

   // Cycles until a freshly issued result can be consumed.
   function automatic sb_cnt_t issue_latency(input logic is_load, input int alu_lat,
                                             input int load_lat, input int forwarding);
      int lat;
      lat = (is_load ? load_lat : alu_lat) + ((forwarding != 0) ? 0 : WB_EXTRA);
      return sb_cnt_t'(lat);
   endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-stage and memory-port signals between the pipeline and the hazard controller.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_scoreboard_if
   import pipe_hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2
);
   logic                          id_valid;
   logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
   logic [NUM_SRC-1:0]            id_src_used;
   logic [NUM_SRC-1:0]            id_src_late;
   logic [NUM_SRC-1:0]            id_src_early;
   logic [REG_ADDR_W-1:0]         id_dst_addr;
   logic                          id_dst_we;
   logic                          id_is_load;
   logic                          flush;
   logic                          mem_req;
   logic                          mem_ready;
   logic                          pc_write;
   logic                          if_id_write;
   logic                          id_ex_bubble;
   logic                          fetch_mem_sel;
   stall_cause_t                  stall_cause;

   modport master (
      output id_valid, id_src_addr, id_src_used, id_src_late, id_src_early,
             id_dst_addr, id_dst_we, id_is_load, flush, mem_req, mem_ready,
      input  pc_write, if_id_write, id_ex_bubble, fetch_mem_sel, stall_cause
   );

   modport slave (
      input  id_valid, id_src_addr, id_src_used, id_src_late, id_src_early,
             id_dst_addr, id_dst_we, id_is_load, flush, mem_req, mem_ready,
      output pc_write, if_id_write, id_ex_bubble, fetch_mem_sel, stall_cause
   );
endinterface

// File: rtl/pipe_hazard_scoreboard_regsb.sv
// Per-register countdown scoreboard: cycles until each in-flight result is consumable.
// A source is blocked while its counter exceeds the consumer's slack:
//   normal source: 1 with bypass (consumed in EX), 0 without (read in ID)
//   late source  : one more than normal
//   early source : one less than normal, floored at 0
module pipe_reg_scoreboard
   import pipe_hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int ALU_LAT    = 1,
   parameter int LOAD_LAT   = 2,
   parameter int FORWARDING = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] i_src_addr,
   input  logic [NUM_SRC-1:0]            i_src_used,
   input  logic [NUM_SRC-1:0]            i_src_late,
   input  logic [NUM_SRC-1:0]            i_src_early,
   input  logic                          i_hold,
   input  logic                          i_set,
   input  logic [REG_ADDR_W-1:0]         i_set_addr,
   input  logic                          i_set_load,
   output logic [NUM_SRC-1:0]            o_src_blocked
);
   localparam int      NUM_REGS   = 2**REG_ADDR_W;
   localparam sb_cnt_t SLACK_BASE = (FORWARDING != 0) ? sb_cnt_t'(1) : sb_cnt_t'(0);

   sb_cnt_t               r_cnt [NUM_REGS];
   sb_cnt_t               w_set_val;
   logic [REG_ADDR_W-1:0] w_addr;
   sb_cnt_t               w_slack;

   assign w_set_val = issue_latency(i_set_load, ALU_LAT, LOAD_LAT, FORWARDING);

   // Load on issue (set beats decrement), else count down; everything holds while memory stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      end else if (!i_hold) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (i_set && (i_set_addr == REG_ADDR_W'(r))) r_cnt[r] <= w_set_val;
            else if (r_cnt[r] != '0)                     r_cnt[r] <= r_cnt[r] - sb_cnt_t'(1);
         end
      end
   end

   // Per-source compare of the producer countdown against the consumer slack.
   always_comb begin
      o_src_blocked = '0;
      w_addr        = '0;
      w_slack       = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_addr = i_src_addr[i*REG_ADDR_W +: REG_ADDR_W];
         if (i_src_early[i] && !i_src_late[i])      w_slack = '0;
         else if (i_src_late[i] && !i_src_early[i]) w_slack = SLACK_BASE + sb_cnt_t'(1);
         else                                       w_slack = SLACK_BASE;
         o_src_blocked[i] = i_src_used[i] && (w_addr != '0) && (r_cnt[w_addr] > w_slack);
      end
   end
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard and stall controller beside IF/ID: data-hazard stalls from the register
// scoreboard, shared memory port arbitration, pipeline enables and a stall counter.
module pipe_hazard_scoreboard
   import pipe_hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int ALU_LAT    = 1,
   parameter int LOAD_LAT   = 2,
   parameter int FORWARDING = 1,
   parameter int CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   pipe_hazard_scoreboard_if.slave bus,
   output logic [CNT_W-1:0]       stall_cycles
);
   logic [NUM_SRC-1:0] w_src_blocked;
   logic               w_data_stall;
   logic               w_mem_stall;
   logic               w_fetch_stall;
   logic               w_id_fire;
   logic               w_set;
   logic               w_pc_write;
   logic [CNT_W-1:0]   r_stall_cycles;

   assign w_data_stall  = bus.id_valid && !bus.flush && (|w_src_blocked);
   assign w_mem_stall   = bus.mem_req && !bus.mem_ready;
   // The single port serves the data access whenever one is requested, so fetch waits.
   assign w_fetch_stall = bus.mem_req;
   assign w_id_fire     = bus.id_valid && !bus.flush && !w_data_stall && !w_mem_stall;
   assign w_set         = w_id_fire && bus.id_dst_we && (bus.id_dst_addr != '0);

   pipe_reg_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_SRC    (NUM_SRC),
      .ALU_LAT    (ALU_LAT),
      .LOAD_LAT   (LOAD_LAT),
      .FORWARDING (FORWARDING)
   ) u_sb (
      .clk           (clk),
      .reset         (reset),
      .i_src_addr    (bus.id_src_addr),
      .i_src_used    (bus.id_src_used),
      .i_src_late    (bus.id_src_late),
      .i_src_early   (bus.id_src_early),
      .i_hold        (w_mem_stall),
      .i_set         (w_set),
      .i_set_addr    (bus.id_dst_addr),
      .i_set_load    (bus.id_is_load),
      .o_src_blocked (w_src_blocked)
   );

   // Pipeline enables, bubble select, port select and debug stall cause.
   always_comb begin
      w_pc_write        = !(w_data_stall || w_fetch_stall);
      bus.pc_write      = w_pc_write;
      bus.if_id_write   = w_pc_write || bus.flush;
      bus.id_ex_bubble  = (w_data_stall || bus.flush || !bus.id_valid) && !w_mem_stall;
      bus.fetch_mem_sel = !bus.mem_req;
      bus.stall_cause   = NONE;
      if (w_fetch_stall)     bus.stall_cause = MEM;
      else if (w_data_stall) bus.stall_cause = DATA;
      else if (bus.flush)    bus.stall_cause = FLUSH;
   end

   // Saturating count of cycles with the PC frozen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                                    r_stall_cycles <= '0;
      else if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}}))   r_stall_cycles <= r_stall_cycles + 1'b1;
   end

   assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: one bypassed build and one register-file-only
// build (narrow stall counter) share the same ID/memory stimulus.
module tb_pipe_hazard_scoreboard;
   import pipe_hazard_pkg::*;

   localparam int RW    = 5;
   localparam int NS    = 2;
   localparam int CNT_F = 16;
   localparam int CNT_N = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic             s_valid;
   logic [NS*RW-1:0] s_src_addr;
   logic [NS-1:0]    s_used, s_late, s_early;
   logic [RW-1:0]    s_dst;
   logic             s_we, s_ld, s_flush, s_mreq, s_mrdy;

   logic [CNT_F-1:0] stall_f;
   logic [CNT_N-1:0] stall_n;

   pipe_hazard_scoreboard_if #(.REG_ADDR_W(RW), .NUM_SRC(NS)) bus_f ();
   pipe_hazard_scoreboard_if #(.REG_ADDR_W(RW), .NUM_SRC(NS)) bus_n ();

   assign bus_f.id_valid     = s_valid;
   assign bus_f.id_src_addr  = s_src_addr;
   assign bus_f.id_src_used  = s_used;
   assign bus_f.id_src_late  = s_late;
   assign bus_f.id_src_early = s_early;
   assign bus_f.id_dst_addr  = s_dst;
   assign bus_f.id_dst_we    = s_we;
   assign bus_f.id_is_load   = s_ld;
   assign bus_f.flush        = s_flush;
   assign bus_f.mem_req      = s_mreq;
   assign bus_f.mem_ready    = s_mrdy;

   assign bus_n.id_valid     = s_valid;
   assign bus_n.id_src_addr  = s_src_addr;
   assign bus_n.id_src_used  = s_used;
   assign bus_n.id_src_late  = s_late;
   assign bus_n.id_src_early = s_early;
   assign bus_n.id_dst_addr  = s_dst;
   assign bus_n.id_dst_we    = s_we;
   assign bus_n.id_is_load   = s_ld;
   assign bus_n.flush        = s_flush;
   assign bus_n.mem_req      = s_mreq;
   assign bus_n.mem_ready    = s_mrdy;

   pipe_hazard_scoreboard #(
      .REG_ADDR_W(RW), .NUM_SRC(NS), .ALU_LAT(1), .LOAD_LAT(2), .FORWARDING(1), .CNT_W(CNT_F)
   ) u_dut_fwd (
      .clk(clk), .reset(reset), .bus(bus_f), .stall_cycles(stall_f)
   );

   pipe_hazard_scoreboard #(
      .REG_ADDR_W(RW), .NUM_SRC(NS), .ALU_LAT(1), .LOAD_LAT(2), .FORWARDING(0), .CNT_W(CNT_N)
   ) u_dut_nofwd (
      .clk(clk), .reset(reset), .bus(bus_n), .stall_cycles(stall_n)
   );

   typedef struct {
      logic         pc_write;
      logic         if_id_write;
      logic         id_ex_bubble;
      logic         fetch_mem_sel;
      stall_cause_t cause;
      int           stall_cnt;
   } exp_t;

   exp_t q_f[$];
   exp_t q_n[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: each register's result becomes usable at an absolute point on
   // a timeline that only advances on cycles where the producers are not frozen.
   int t_act;
   int ready_f [32];
   int ready_n [32];
   int stall_cnt_f, stall_cnt_n;

   function automatic void chk(input string name, input longint got, input longint expv);
      n_tests++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
      end
   endfunction

   function automatic void model_clear();
      t_act = 0;
      for (int r = 0; r < 32; r++) begin
         ready_f[r] = 0;
         ready_n[r] = 0;
      end
      stall_cnt_f = 0;
      stall_cnt_n = 0;
   endfunction

   function automatic bit model_blocked(input bit fwd);
      bit blk = 1'b0;
      for (int i = 0; i < NS; i++) begin
         int a;
         int rem;
         int slack;
         a     = int'(s_src_addr[i*RW +: RW]);
         rem   = (fwd ? ready_f[a] : ready_n[a]) - t_act;
         if (rem < 0) rem = 0;
         slack = (fwd ? 1 : 0) + int'(s_late[i]) - int'(s_early[i]);
         if (slack < 0) slack = 0;
         if (s_used[i] && (a != 0) && (rem > slack)) blk = 1'b1;
      end
      return blk;
   endfunction

   function automatic exp_t model_out(input bit fwd);
      exp_t e;
      bit   ds, ms;
      ds = s_valid && !s_flush && model_blocked(fwd);
      ms = s_mreq && !s_mrdy;
      e.pc_write      = !(ds || s_mreq);
      e.if_id_write   = e.pc_write || s_flush;
      e.id_ex_bubble  = (ds || s_flush || !s_valid) && !ms;
      e.fetch_mem_sel = !s_mreq;
      e.cause         = s_mreq ? MEM : (ds ? DATA : (s_flush ? FLUSH : NONE));
      e.stall_cnt     = fwd ? stall_cnt_f : stall_cnt_n;
      return e;
   endfunction

   task automatic push_exp();
      q_f.push_back(model_out(1'b1));
      q_n.push_back(model_out(1'b0));
   endtask

   // Close the current cycle at the rising edge and move the reference forward.
   task automatic advance();
      bit df, dn, ms;
      int lat_f, lat_n;
      @(posedge clk);
      if (reset) begin
         model_clear();
      end else begin
         ms    = s_mreq && !s_mrdy;
         df    = s_valid && !s_flush && model_blocked(1'b1);
         dn    = s_valid && !s_flush && model_blocked(1'b0);
         lat_f = s_ld ? 2 : 1;
         lat_n = lat_f + 2;
         if (df || s_mreq) stall_cnt_f = (stall_cnt_f == (1 << CNT_F) - 1) ? stall_cnt_f : stall_cnt_f + 1;
         if (dn || s_mreq) stall_cnt_n = (stall_cnt_n == (1 << CNT_N) - 1) ? stall_cnt_n : stall_cnt_n + 1;
         if (s_valid && !s_flush && !ms && s_we && (s_dst != '0)) begin
            if (!df) ready_f[int'(s_dst)] = t_act + 1 + lat_f;
            if (!dn) ready_n[int'(s_dst)] = t_act + 1 + lat_n;
         end
         if (!ms) t_act++;
      end
      #1;
   endtask

   task automatic step_cnt(output bit pf, output bit pn);
      push_exp();
      @(negedge clk);
      #1;
      pf = bus_f.pc_write;
      pn = bus_n.pc_write;
      advance();
   endtask

   task automatic step();
      bit pf, pn;
      step_cnt(pf, pn);
   endtask

   task automatic idle();
      s_valid = 1'b0; s_src_addr = '0; s_used = '0; s_late = '0; s_early = '0;
      s_dst = '0; s_we = 1'b0; s_ld = 1'b0; s_flush = 1'b0; s_mreq = 1'b0; s_mrdy = 1'b0;
   endtask

   task automatic instr(input int dst, input bit we, input bit ld,
                        input int a0, input bit u0, input int a1, input bit u1);
      s_valid = 1'b1;
      s_src_addr[RW-1:0]    = RW'(a0);
      s_src_addr[2*RW-1:RW] = RW'(a1);
      s_used  = {u1, u0};
      s_early = '0;
      s_late  = '0;
      s_dst   = RW'(dst);
      s_we    = we;
      s_ld    = ld;
      s_flush = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q_f.size() > 0) begin
         e = q_f.pop_front();
         chk("fwd_pc_write",      longint'(bus_f.pc_write),      longint'(e.pc_write));
         chk("fwd_if_id_write",   longint'(bus_f.if_id_write),   longint'(e.if_id_write));
         chk("fwd_id_ex_bubble",  longint'(bus_f.id_ex_bubble),  longint'(e.id_ex_bubble));
         chk("fwd_fetch_mem_sel", longint'(bus_f.fetch_mem_sel), longint'(e.fetch_mem_sel));
         chk("fwd_stall_cause",   longint'(bus_f.stall_cause),   longint'(e.cause));
         chk("fwd_stall_cycles",  longint'(stall_f),             longint'(e.stall_cnt));
      end
      while (q_n.size() > 0) begin
         e = q_n.pop_front();
         chk("nofwd_pc_write",      longint'(bus_n.pc_write),      longint'(e.pc_write));
         chk("nofwd_if_id_write",   longint'(bus_n.if_id_write),   longint'(e.if_id_write));
         chk("nofwd_id_ex_bubble",  longint'(bus_n.id_ex_bubble),  longint'(e.id_ex_bubble));
         chk("nofwd_fetch_mem_sel", longint'(bus_n.fetch_mem_sel), longint'(e.fetch_mem_sel));
         chk("nofwd_stall_cause",   longint'(bus_n.stall_cause),   longint'(e.cause));
         chk("nofwd_stall_cycles",  longint'(stall_n),             longint'(e.stall_cnt));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pf, pn;
      int low_f, low_n;

      reset = 1'b1;
      idle();
      model_clear();
      @(posedge clk);
      #1;
      repeat (3) step();
      reset = 1'b0;

      // Load followed by a dependent ALU op
      instr(8, 1, 1, 0, 0, 0, 0);
      step();
      low_f = 0;
      repeat (2) begin
         instr(10, 1, 0, 8, 1, 0, 0);
         step_cnt(pf, pn);
         if (!pf) low_f++;
      end
      chk("t1_load_use_stalls", low_f, 1);
      chk("t1_stall_counter", longint'(stall_f), 1);

      // ALU result consumed by a branch in ID
      idle();
      repeat (6) step();
      instr(9, 1, 0, 0, 0, 0, 0);
      step();
      low_f = 0;
      repeat (2) begin
         instr(0, 0, 0, 9, 1, 0, 0);
         s_early = 2'b01;
         step_cnt(pf, pn);
         if (!pf) low_f++;
      end
      chk("t2_branch_stalls", low_f, 1);
      instr(9, 1, 0, 0, 0, 0, 0);
      step();
      instr(11, 1, 0, 0, 0, 0, 0);
      step();
      instr(0, 0, 0, 9, 1, 0, 0);
      s_early = 2'b01;
      step_cnt(pf, pn);
      chk("t2_branch_indep_pc_write", longint'(pf), 1);

      // Register-file-only build adds the writeback delay
      idle();
      repeat (6) step();
      instr(3, 1, 0, 0, 0, 0, 0);
      step();
      low_f = 0;
      low_n = 0;
      repeat (4) begin
         instr(4, 1, 0, 3, 1, 0, 0);
         step_cnt(pf, pn);
         if (!pf) low_f++;
         if (!pn) low_n++;
      end
      chk("t3_nofwd_alu_stalls", low_n, 3);
      chk("t3_fwd_alu_stalls", low_f, 0);
      idle();
      repeat (6) step();
      instr(0, 1, 1, 0, 0, 0, 0);
      step();
      low_f = 0;
      low_n = 0;
      repeat (2) begin
         instr(0, 1, 0, 0, 1, 0, 1);
         step_cnt(pf, pn);
         if (!pf) low_f++;
         if (!pn) low_n++;
      end
      chk("t3_zero_reg_stalls", low_f + low_n, 0);

      // Multi-cycle memory handshake freezes the pipeline
      idle();
      repeat (6) step();
      instr(8, 1, 1, 0, 0, 0, 0);
      step();
      instr(0, 0, 0, 8, 1, 0, 0);
      s_mreq = 1'b1;
      s_mrdy = 1'b0;
      low_f = 0;
      repeat (3) begin
         step_cnt(pf, pn);
         if (!pf) low_f++;
      end
      s_mrdy = 1'b1;
      step_cnt(pf, pn);
      if (!pf) low_f++;
      chk("t4_mem_pc_low_cycles", low_f, 4);
      s_mreq = 1'b0;
      s_mrdy = 1'b0;
      low_f = 0;
      repeat (2) begin
         step_cnt(pf, pn);
         if (!pf) low_f++;
      end
      chk("t4_after_mem_stalls", low_f, 0);

      // Flush beats a pending data stall
      idle();
      repeat (6) step();
      instr(8, 1, 1, 0, 0, 0, 0);
      step();
      instr(12, 1, 0, 8, 1, 0, 0);
      s_flush = 1'b1;
      push_exp();
      @(negedge clk);
      #1;
      chk("t5_flush_if_id_write", longint'(bus_f.if_id_write), 1);
      chk("t5_flush_bubble", longint'(bus_f.id_ex_bubble), 1);
      advance();
      instr(0, 0, 0, 12, 1, 0, 0);
      step_cnt(pf, pn);
      chk("t5_no_set_after_flush", longint'(pf) + longint'(pn), 2);

      // Asynchronous reset in the middle of a load-use stall
      idle();
      repeat (6) step();
      instr(8, 1, 1, 0, 0, 0, 0);
      step();
      instr(0, 0, 0, 8, 1, 0, 0);
      push_exp();
      @(negedge clk);
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      chk("t6_reset_pc_write", longint'(bus_f.pc_write), 1);
      chk("t6_reset_stall_cycles", longint'(stall_f), 0);
      chk("t6_reset_bubble", longint'(bus_f.id_ex_bubble), 0);
      advance();
      reset = 1'b0;
      step_cnt(pf, pn);
      chk("t6_no_stall_after_reset", longint'(pf), 1);

      // Randomized traffic with occasional resets
      for (int c = 0; c < 600; c++) begin
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            model_clear();
         end
         s_valid = ($urandom_range(0, 9) < 8);
         for (int i = 0; i < NS; i++) begin
            s_src_addr[i*RW +: RW] = RW'($urandom_range(0, 7));
            s_used[i]  = ($urandom_range(0, 3) != 0);
            s_early[i] = ($urandom_range(0, 5) == 0);
            s_late[i]  = ($urandom_range(0, 5) == 0);
         end
         s_dst   = RW'($urandom_range(0, 7));
         s_we    = ($urandom_range(0, 3) != 0);
         s_ld    = ($urandom_range(0, 2) == 0);
         s_flush = ($urandom_range(0, 9) == 0);
         s_mreq  = ($urandom_range(0, 4) == 0);
         s_mrdy  = ($urandom_range(0, 1) == 1);
         step();
      end
      reset = 1'b0;
      idle();

      repeat (3) @(negedge clk);
      chk("queue_drained", longint'(q_f.size() + q_n.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
